// File: rtl/time_field_counter_pkg.sv
// ---------------------------------------------------------------------------
// time_pkg : shared types and BCD helpers for the time field counter.
//
// Contents:
//   bcd_digit_t  - one 4-bit BCD digit
//   bcd_field_t  - two-digit BCD field {tens, ones}
//   FIELD_W      - bit width of one field (8)
//   int_to_bcd   - converts a small integer (0..99) into a BCD field
//   bcd_inc      - increments a field, wrapping the terminal value to 00
//   bcd_dec      - decrements a field, wrapping 00 to the terminal value
//   bcd_clamp    - saturates an illegal or too-large field to the terminal value
// ---------------------------------------------------------------------------
package time_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t ones;
  } bcd_field_t;

  localparam int FIELD_W = 8;

  // Builds the BCD form of a decimal constant, used to turn the integer
  // terminal-value parameter into something comparable with a field.
  function automatic bcd_field_t int_to_bcd(input int n);
    bcd_field_t r;
    r.tens = 4'(n / 10);
    r.ones = 4'(n % 10);
    return r;
  endfunction

  // Valid BCD orders the same way as plain binary, so a numeric compare
  // against the terminal value is enough to detect the wrap point.
  function automatic bcd_field_t bcd_inc(input bcd_field_t v, input bcd_field_t maxv);
    bcd_field_t r;
    r = v;
    if (v >= maxv) begin
      r = '0;
    end else if (v.ones == 4'd9) begin
      r.tens = v.tens + 4'd1;
      r.ones = 4'd0;
    end else begin
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

  // Mirror of bcd_inc: 00 wraps up to the terminal value, ones 0 borrows.
  function automatic bcd_field_t bcd_dec(input bcd_field_t v, input bcd_field_t maxv);
    bcd_field_t r;
    r = v;
    if (v == '0) begin
      r = maxv;
    end else if (v.ones == 4'd0) begin
      r.tens = v.tens - 4'd1;
      r.ones = 4'd9;
    end else begin
      r.ones = v.ones - 4'd1;
    end
    return r;
  endfunction

  // A non-decimal nibble or a value beyond the terminal value both land on
  // the terminal value, so a bad load can never leave an illegal field.
  function automatic bcd_field_t bcd_clamp(input bcd_field_t v, input bcd_field_t maxv);
    bcd_field_t r;
    r = v;
    if ((v.tens > 4'd9) || (v.ones > 4'd9) || (v > maxv)) begin
      r = maxv;
    end
    return r;
  endfunction

endpackage

// File: rtl/time_field_counter_if.sv
// ---------------------------------------------------------------------------
// time_field_counter_if : control and display bus of the time field counter.
//
// Signals:
//   tick_run  - one-cycle run-rate enable
//   tick_adj  - one-cycle adjust-rate enable
//   pause     - level, holds the count in run mode
//   adj       - level, 1 selects adjust mode
//   sel       - field to adjust (SEL_W bits)
//   load      - one-cycle parallel load strobe
//   load_val  - BCD load value, field f at [8f+7:8f]
//   dir       - count direction, only present with DOWN_COUNT_EN defined
//   digits    - current BCD value, same packing as load_val
//   rollover  - one-cycle pulse when every field wraps together
//   led       - adjust-mode blink indicator
//
// Modports: master drives the controls (testbench / upstream logic),
//           slave is the counter itself.
// Optional macro: DOWN_COUNT_EN adds the dir signal.
// ---------------------------------------------------------------------------
interface time_field_counter_if #(
  parameter int NUM_FIELDS = 2,
  parameter int SEL_W      = 2
) ();

  logic                    tick_run;
  logic                    tick_adj;
  logic                    pause;
  logic                    adj;
  logic [SEL_W-1:0]        sel;
  logic                    load;
  logic [NUM_FIELDS*8-1:0] load_val;
`ifdef DOWN_COUNT_EN
  logic                    dir;
`endif
  logic [NUM_FIELDS*8-1:0] digits;
  logic                    rollover;
  logic                    led;

`ifdef DOWN_COUNT_EN
  modport master (
    output tick_run, tick_adj, pause, adj, sel, load, load_val, dir,
    input  digits, rollover, led
  );

  modport slave (
    input  tick_run, tick_adj, pause, adj, sel, load, load_val, dir,
    output digits, rollover, led
  );
`else
  modport master (
    output tick_run, tick_adj, pause, adj, sel, load, load_val,
    input  digits, rollover, led
  );

  modport slave (
    input  tick_run, tick_adj, pause, adj, sel, load, load_val,
    output digits, rollover, led
  );
`endif

endinterface

// File: rtl/time_field_counter_bcd_field.sv
// ---------------------------------------------------------------------------
// bcd_field : one two-digit BCD register of the time counter.
//
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset, clears the field
//   inc     - step the field up one (terminal value wraps to 00)
//   dec     - step the field down one (00 wraps to terminal value)
//   load    - take ld_val, saturated to the terminal value
//   ld_val  - BCD load value
//   value   - registered field value
//   at_max  - field currently equals the terminal value
//   at_zero - field currently equals 00
// ---------------------------------------------------------------------------
module bcd_field
  import time_pkg::*;
#(
  parameter bcd_field_t MAX_BCD = 8'h59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  bcd_field_t ld_val,
  output bcd_field_t value,
  output logic       at_max,
  output logic       at_zero
);

  bcd_field_t r_value;

  // Field register. Load beats stepping; the top never asks for inc and dec
  // together, but inc is given precedence so the behaviour stays defined.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= '0;
    end else if (load) begin
      r_value <= bcd_clamp(ld_val, MAX_BCD);
    end else if (inc) begin
      r_value <= bcd_inc(r_value, MAX_BCD);
    end else if (dec) begin
      r_value <= bcd_dec(r_value, MAX_BCD);
    end
  end

  assign value   = r_value;
  assign at_max  = (r_value == MAX_BCD);
  assign at_zero = (r_value == '0);

endmodule

// File: rtl/time_field_counter.sv
// ---------------------------------------------------------------------------
// time_field_counter : BCD time counter/adjuster with NUM_FIELDS two-digit
// fields (field 0 least significant), e.g. MM:SS or HH:MM:SS.
//
// Run mode (adj=0) counts on tick_run with carry between fields; adjust mode
// (adj=1) steps only field sel on tick_adj with no carry and blinks led.
// Priority each cycle: rst > load > adj > run.
//
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - time_field_counter_if.slave (ticks, mode, load, digits, rollover, led)
//
// Parameters:
//   NUM_FIELDS - number of two-digit fields
//   FIELD_MAX  - terminal value of every field (1..99)
//   SEL_W      - width of sel, 2**SEL_W >= NUM_FIELDS
//
// Optional macro: DOWN_COUNT_EN adds bus.dir; dir=1 makes run and adjust
// count down with borrow, and all-zero wraps to all-FIELD_MAX with rollover.
// ---------------------------------------------------------------------------
module time_field_counter
  import time_pkg::*;
#(
  parameter int NUM_FIELDS = 2,
  parameter int FIELD_MAX  = 59,
  parameter int SEL_W      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  time_field_counter_if.slave  bus
);

  localparam bcd_field_t MAX_BCD = int_to_bcd(FIELD_MAX);

  logic [NUM_FIELDS-1:0][FIELD_W-1:0] w_value;
  logic [NUM_FIELDS-1:0]              w_atMax;
  logic [NUM_FIELDS-1:0]              w_atZero;
  logic [NUM_FIELDS-1:0]              w_inc;
  logic [NUM_FIELDS-1:0]              w_dec;
  logic [NUM_FIELDS:0]                w_chainMax;
  logic [NUM_FIELDS:0]                w_chainZero;
  logic                               w_dirDown;
  logic                               w_runStep;
  logic                               w_runUp;
  logic                               w_runDn;
  logic                               w_adjStep;
  logic                               w_adjUp;
  logic                               w_adjDn;
  logic                               r_rollover;
  logic                               r_led;

`ifdef DOWN_COUNT_EN
  assign w_dirDown = bus.dir;
`else
  assign w_dirDown = 1'b0;
`endif

  // Qualified step enables. A load in the same cycle swallows any tick, and
  // only the enable belonging to the current mode is honoured.
  assign w_runStep = ~bus.load & ~bus.adj & bus.tick_run & ~bus.pause;
  assign w_adjStep = ~bus.load &  bus.adj & bus.tick_adj;
  assign w_runUp   = w_runStep & ~w_dirDown;
  assign w_runDn   = w_runStep &  w_dirDown;
  assign w_adjUp   = w_adjStep & ~w_dirDown;
  assign w_adjDn   = w_adjStep &  w_dirDown;

  // Carry/borrow chain: entry f is true when every field below f sits at the
  // wrap point, so field f steps together with all lower fields wrapping.
  // The final entry means the whole counter wraps, which drives rollover.
  // A sel value beyond the last field simply matches no field.
  always_comb begin
    w_chainMax    = '0;
    w_chainZero   = '0;
    w_inc         = '0;
    w_dec         = '0;
    w_chainMax[0]  = 1'b1;
    w_chainZero[0] = 1'b1;
    for (int f = 0; f < NUM_FIELDS; f++) begin
      w_chainMax[f+1]  = w_chainMax[f]  & w_atMax[f];
      w_chainZero[f+1] = w_chainZero[f] & w_atZero[f];
      w_inc[f] = (w_runUp & w_chainMax[f]) |
                 (w_adjUp & (bus.sel == SEL_W'(f)));
      w_dec[f] = (w_runDn & w_chainZero[f]) |
                 (w_adjDn & (bus.sel == SEL_W'(f)));
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_FIELDS; g++) begin : g_field
      bcd_field #(
        .MAX_BCD (MAX_BCD)
      ) u_field (
        .clk     (clk),
        .rst     (rst),
        .inc     (w_inc[g]),
        .dec     (w_dec[g]),
        .load    (bus.load),
        .ld_val  (bus.load_val[g*FIELD_W +: FIELD_W]),
        .value   (w_value[g]),
        .at_max  (w_atMax[g]),
        .at_zero (w_atZero[g])
      );
    end
  endgenerate

  // Rollover pulses for the single run step that wraps every field at once;
  // it is recomputed each cycle so it can never stretch past one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rollover <= 1'b0;
    end else begin
      r_rollover <= (w_runUp & w_chainMax[NUM_FIELDS]) |
                    (w_runDn & w_chainZero[NUM_FIELDS]);
    end
  end

  // Blink indicator: toggles on each accepted adjust tick and is cleared on
  // the first edge that sees run mode, so it never lingers after adjusting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_led <= 1'b0;
    end else if (~bus.adj) begin
      r_led <= 1'b0;
    end else if (w_adjStep) begin
      r_led <= ~r_led;
    end
  end

  assign bus.digits   = w_value;
  assign bus.rollover = r_rollover;
  assign bus.led      = r_led;

endmodule

// File: tb/tb_time_field_counter.sv
// ---------------------------------------------------------------------------
// tb_time_field_counter : scoreboard bench for time_field_counter
// (NUM_FIELDS=2, FIELD_MAX=59). Stimulus pushes the hand-computed expected
// outputs into a queue; an independent monitor pops and compares them.
// Optional macro: DOWN_COUNT_EN enables the down-count directed vectors.
// ---------------------------------------------------------------------------
module tb_time_field_counter;

  localparam int NUM_FIELDS = 2;
  localparam int FIELD_MAX  = 59;
  localparam int SEL_W      = 2;

  typedef struct {
    logic [15:0] digits;
    logic        rollover;
    logic        led;
    string       name;
  } exp_t;

  logic clk;
  logic rst;
  exp_t expQ[$];
  int   checks;
  int   errors;

  time_field_counter_if #(.NUM_FIELDS(NUM_FIELDS), .SEL_W(SEL_W)) bus ();

  time_field_counter #(
    .NUM_FIELDS (NUM_FIELDS),
    .FIELD_MAX  (FIELD_MAX),
    .SEL_W      (SEL_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal seconds count to the expected MM:SS BCD value.
  function automatic logic [15:0] mmss(input int n);
    int m;
    int s;
    m = (n / 60) % 60;
    s = n % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // Drives one clock of pulse inputs, then releases them just after the edge.
  task automatic applyStimulus(input logic tr, input logic ta,
                               input logic ld, input logic [15:0] lv);
    bus.tick_run = tr;
    bus.tick_adj = ta;
    bus.load     = ld;
    bus.load_val = lv;
    @(posedge clk);
    #1;
    bus.tick_run = 1'b0;
    bus.tick_adj = 1'b0;
    bus.load     = 1'b0;
  endtask

  // Queues the outputs expected right after the edge just applied.
  task automatic checkOutput(input string name, input logic [15:0] d,
                             input logic r, input logic l);
    exp_t e;
    e.digits   = d;
    e.rollover = r;
    e.led      = l;
    e.name     = name;
    expQ.push_back(e);
  endtask

  // Monitor: compares on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checks++;
      if (bus.digits !== e.digits || bus.rollover !== e.rollover || bus.led !== e.led) begin
        errors++;
        $display("[TB] FAIL %s: got digits=%h rollover=%b led=%b, expected digits=%h rollover=%b led=%b",
                 e.name, bus.digits, bus.rollover, bus.led, e.digits, e.rollover, e.led);
      end
    end
  end

  // Directed stimulus
  initial begin
    checks = 0;
    errors = 0;
    bus.tick_run = 1'b0;
    bus.tick_adj = 1'b0;
    bus.pause    = 1'b0;
    bus.adj      = 1'b0;
    bus.sel      = '0;
    bus.load     = 1'b0;
    bus.load_val = '0;
`ifdef DOWN_COUNT_EN
    bus.dir      = 1'b0;
`endif
    rst = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    checkOutput("reset", 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;

    // 60 run ticks from zero: one minute, never a rollover
    for (int i = 1; i <= 60; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
      checkOutput("run60", mmss(i), 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("run60_hold", 16'h0100, 1'b0, 1'b0);

    // load near the top and roll over
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h5958);
    checkOutput("load5958", 16'h5958, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("to5959", 16'h5959, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("rollover", 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("rollover_end", 16'h0000, 1'b0, 1'b0);

    // adjust mode: no carry, led toggles, tick_run ignored
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h1259);
    checkOutput("load1259", 16'h1259, 1'b0, 1'b0);
    bus.adj = 1'b1;
    bus.sel = 2'd0;
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("adj_wrap", 16'h1200, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("adj_ignore_run", 16'h1200, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    checkOutput("adj_both_ticks", 16'h1201, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("adj_third", 16'h1202, 1'b0, 1'b1);
    bus.sel = 2'd1;
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("adj_sel1", 16'h1302, 1'b0, 1'b0);
    bus.sel = 2'd2;
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("adj_sel_oob", 16'h1302, 1'b0, 1'b1);
    bus.adj = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("led_cleared", 16'h1302, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("run_after_adj", 16'h1303, 1'b0, 1'b0);

    // load saturation, tick dropped in the load cycle
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h7A99);
    checkOutput("load_sat", 16'h5959, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h6012);
    checkOutput("load_over_max", 16'h5912, 1'b0, 1'b0);

    // pause holds and discards ticks
    bus.pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
      checkOutput("pause_hold", 16'h5912, 1'b0, 1'b0);
    end
    bus.pause = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("unpause", 16'h5913, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("no_queued_ticks", 16'h5913, 1'b0, 1'b0);

    // reset in the middle of adjusting, with a tick_adj in the same cycle
    bus.adj = 1'b1;
    bus.sel = 2'd0;
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("adj_before_rst", 16'h5914, 1'b0, 1'b1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("rst_mid_adj", 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    bus.adj = 1'b0;

`ifdef DOWN_COUNT_EN
    // down counting: all-zero wraps to all-max with rollover, then borrow
    bus.dir = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("down_wrap", 16'h5959, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("down_step", 16'h5958, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0100);
    checkOutput("down_load", 16'h0100, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("down_borrow", 16'h0059, 1'b0, 1'b0);
    bus.adj = 1'b1;
    bus.sel = 2'd1;
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("down_adj_wrap", 16'h5959, 1'b0, 1'b1);
    bus.adj = 1'b0;
    bus.dir = 1'b0;
`endif

    // let the monitor drain, bounded
    for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
      @(posedge clk);
    end
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
